// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: one full-adder slice reused across WIDTH bit positions, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input for a-b via ~b plus carry-in of 1.
module serial_add_seq #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             c_out_r;

    logic             ha0_s;
    logic             ha0_c;
    logic             ha1_s;
    logic             ha1_c;
    logic             cy;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // Full-adder slice as two chained half adders; the carries can never both be set.
    assign ha0_s = sa[0] ^ sb[0];
    assign ha0_c = sa[0] & sb[0];
    assign ha1_s = ha0_s ^ carry;
    assign ha1_c = ha0_s & carry;
    assign cy    = ha0_c | ha1_c;

`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub;
`else
    assign b_load     = b;
    assign carry_load = 1'b0;
`endif

    // A one-bit result register has no upper bits to shift down.
    generate
        if (WIDTH == 1) begin : g_res_narrow
            assign res_next = ha1_s;
        end else begin : g_res_wide
            assign res_next = {ha1_s, res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sa      <= '0;
            sb      <= '0;
            res     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= res_next;
                    carry <= cy;
                    // The counter parks on the last bit position rather than wrapping.
                    if (cnt == LAST_BIT) begin
                        c_out_r <= cy;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign sum       = res;
    assign c_out     = c_out_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: WIDTH=8 main instance plus a WIDTH=1 corner instance.
// Subtract cases run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    logic         in_valid1;
    logic         in_ready1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         out_valid1;
    logic         out_ready1;
    logic [0:0]   sum1;
    logic         c_out1;
    logic         busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    serial_add_seq #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .c_out     (c_out1),
        .busy      (busy1)
    );

    // Reference: plain integer add, or compare-and-subtract where c_out means "no borrow".
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
        int r;
        if (s) begin
            r = int'(x) - int'(y);
            return {(x >= y), W'(r)};
        end
        r = int'(x) + int'(y);
        return (W+1)'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operand pair for a single accepting edge.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        a_in     = x;
        b_in     = y;
        sub_in   = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid; optionally drives junk operands that must be ignored.
    task automatic wait_result(input bit noise, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 3 * W) begin
            if (noise) begin
                in_valid = 1'b1;
                a_in     = W'($urandom);
                b_in     = W'($urandom);
            end
            tick();
            cycles++;
        end
        if (noise) checkOutput("in_ready_low_in_done", 64'(in_ready), 64'd0);
    endtask

    initial begin
        int           cyc;
        int           got;
        int           idx;
        int           lat;
        bit           seen;
        bit           accepted;
        logic [W:0]   expv;
        logic [W-1:0] pa [4];
        logic [W-1:0] pb [4];
        int           acc_cyc[$];
        logic [W:0]   exp_q[$];

        rst        = 1'b1;
        in_valid   = 1'b0;
        a_in       = '0;
        b_in       = '0;
        sub_in     = 1'b0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        out_ready1 = 1'b0;

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_c_out", 64'(c_out), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] 0xFF + 0x01 with latency check");
        out_ready = 1'b1;
        applyStimulus(8'hFF, 8'h01, 1'b0);
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        wait_result(1'b0, lat);
        checkOutput("latency_ff_01", 64'(lat), 64'(W));
        checkOutput("result_ff_01", 64'({c_out, sum}), 64'(ref_result(8'hFF, 8'h01, 1'b0)));
        tick();
        checkOutput("out_valid_after_hs", 64'(out_valid), 64'd0);
        checkOutput("in_ready_after_hs", 64'(in_ready), 64'd1);

        $display("[TB] 0x5A + 0x33 under backpressure with ignored in_valid");
        out_ready = 1'b0;
        applyStimulus(8'h5A, 8'h33, 1'b0);
        wait_result(1'b1, lat);
        checkOutput("latency_5a_33", 64'(lat), 64'(W));
        expv = ref_result(8'h5A, 8'h33, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_result", 64'({c_out, sum}), 64'(expv));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1;
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        checkOutput("hold_result_last", 64'({c_out, sum}), 64'(expv));
        out_ready = 1'b1;
        tick();
        checkOutput("busy_after_release", 64'(busy), 64'd0);

        $display("[TB] reset mid-run");
        applyStimulus(8'hAA, 8'h55, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_sum", 64'(sum), 64'd0);
        checkOutput("abort_c_out", 64'(c_out), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        checkOutput("abort_no_out_valid", 64'(seen), 64'd0);
        applyStimulus(8'h01, 8'h02, 1'b0);
        wait_result(1'b0, lat);
        checkOutput("result_01_02", 64'({c_out, sum}), 64'(ref_result(8'h01, 8'h02, 1'b0)));
        tick();

        $display("[TB] back-to-back random pairs");
        for (int i = 0; i < 4; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        idx      = 0;
        got      = 0;
        cyc      = 0;
        a_in     = pa[0];
        b_in     = pb[0];
        sub_in   = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 20 * W && got < 4; k++) begin
            accepted = in_ready && in_valid;
            tick();
            cyc++;
            if (accepted) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(ref_result(pa[idx], pb[idx], 1'b0));
                idx++;
                if (idx < 4) begin
                    a_in = pa[idx];
                    b_in = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    checkOutput("b2b_result", 64'({c_out, sum}), 64'(exp_q.pop_front()));
                end else begin
                    checkOutput("b2b_unexpected_result", 64'd1, 64'd0);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checkOutput("b2b_result_count", 64'(got), 64'd4);
        checkOutput("b2b_accept_count", 64'(acc_cyc.size()), 64'd4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checkOutput("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(W + 2));
        end
        tick();

`ifdef SERIAL_ADD_SUB_EN
        $display("[TB] subtract");
        applyStimulus(8'h05, 8'h07, 1'b1);
        wait_result(1'b0, lat);
        checkOutput("sub_05_07", 64'({c_out, sum}), 64'(ref_result(8'h05, 8'h07, 1'b1)));
        tick();
        applyStimulus(8'h07, 8'h05, 1'b1);
        wait_result(1'b0, lat);
        checkOutput("sub_07_05", 64'({c_out, sum}), 64'(ref_result(8'h07, 8'h05, 1'b1)));
        tick();
        for (int i = 0; i < 3; i++) begin
            pa[0] = W'($urandom);
            pb[0] = W'($urandom);
            applyStimulus(pa[0], pb[0], 1'b1);
            wait_result(1'b0, lat);
            checkOutput("sub_random", 64'({c_out, sum}), 64'(ref_result(pa[0], pb[0], 1'b1)));
            tick();
        end
        sub_in = 1'b0;
`endif

        $display("[TB] WIDTH=1 instance");
        out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1        = 1'(i);
            b1        = 1'(i >> 1);
            checkOutput("w1_in_ready", 64'(in_ready1), 64'd1);
            in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            checkOutput("w1_run_no_valid", 64'(out_valid1), 64'd0);
            tick();
            checkOutput("w1_out_valid", 64'(out_valid1), 64'd1);
            checkOutput("w1_result", 64'({c_out1, sum1}), 64'((i & 1) + (i >> 1)));
            tick();
        end
        checkOutput("w1_idle_busy", 64'(busy1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
